// File: rtl/gol_sched_pkg.sv
// Shared types for the Game-of-Life generation scheduler.
package gol_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_KICK = 3'd1,
    LOAD_WAIT = 3'd2,
    READY     = 3'd3,
    EVO_KICK  = 3'd4,
    EVO_WAIT  = 3'd5,
    SWAP      = 3'd6,
    ERROR     = 3'd7
  } state_e;

  localparam int DEF_TIMEOUT = 2**20;

endpackage

// File: rtl/toggle_handshake.sv
// Toggle-start / level-finish handshake for one engine, with a cycles-waiting count.
module toggle_handshake #(
  parameter int CNT_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             kick,
  input  logic             waiting,
  input  logic             finish,
  output logic             start,
  output logic             done,
  output logic [CNT_W-1:0] wait_cnt
);

  logic armed;

  // A finish level left high by the previous pass only counts once it has dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start    <= 1'b0;
      armed    <= 1'b0;
      wait_cnt <= '0;
    end else if (kick) begin
      start    <= ~start;
      armed    <= 1'b0;
      wait_cnt <= '0;
    end else if (waiting) begin
      if (!finish) armed <= 1'b1;
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign done = armed & finish;

endmodule

// File: rtl/gen_scheduler.sv
// Sequencer: loads the initial pattern, then paces evolve passes and owns the ping-pong select.
module gen_scheduler
  import gol_sched_pkg::*;
#(
  parameter int PERIOD_W = 24,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int GEN_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run_en,
  input  logic                step_req,
  input  logic                reload_req,
  input  logic [PERIOD_W-1:0] period,
  output logic                init_start,
  input  logic                init_finish,
  output logic                evo_start,
  input  logic                evo_finish,
  output logic                buf_sel,
  output logic [GEN_W-1:0]    gen_count,
  output logic                busy,
  output logic                error,
  output logic [2:0]          state_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e              state;
  logic [PERIOD_W-1:0] tick;
  logic [PERIOD_W-1:0] per_m1;
  logic                run_fire;
  logic                reload_pend;
  logic                init_done, evo_done;
  logic [WD_W-1:0]     init_wd, evo_wd;

  assign per_m1   = (period == '0) ? '0 : period - 1'b1;
  assign run_fire = run_en && (tick >= per_m1);

  toggle_handshake #(.CNT_W(WD_W)) u_init (
    .clk      (clk),
    .rst_n    (rst_n),
    .kick     (state == LOAD_KICK),
    .waiting  (state == LOAD_WAIT),
    .finish   (init_finish),
    .start    (init_start),
    .done     (init_done),
    .wait_cnt (init_wd)
  );

  toggle_handshake #(.CNT_W(WD_W)) u_evo (
    .clk      (clk),
    .rst_n    (rst_n),
    .kick     (state == EVO_KICK),
    .waiting  (state == EVO_WAIT),
    .finish   (evo_finish),
    .start    (evo_start),
    .done     (evo_done),
    .wait_cnt (evo_wd)
  );

  // The tick runs in every state while run_en is high, so the start-to-start
  // spacing stays at the programmed period regardless of pass length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      buf_sel     <= 1'b0;
      gen_count   <= '0;
      error       <= 1'b0;
      tick        <= '0;
      reload_pend <= 1'b0;
    end else begin
      if (run_en && tick != '1) tick <= tick + 1'b1;
      case (state)
        IDLE: state <= LOAD_KICK;
        LOAD_KICK: begin
          buf_sel     <= 1'b0;
          gen_count   <= '0;
          tick        <= '0;
          reload_pend <= 1'b0;
          state       <= LOAD_WAIT;
        end
        LOAD_WAIT: begin
          if (init_done) state <= READY;
          else if (init_wd == WD_LAST) begin
            state <= ERROR;
            error <= 1'b1;
          end
        end
        READY: begin
          if (reload_req || reload_pend) state <= LOAD_KICK;
          else if (!run_en && step_req) state <= EVO_KICK;
          else if (run_fire) begin
            tick  <= '0;
            state <= EVO_KICK;
          end
        end
        EVO_KICK: begin
          if (reload_req) reload_pend <= 1'b1;
          state <= EVO_WAIT;
        end
        EVO_WAIT: begin
          if (evo_done) begin
            state       <= (reload_pend || reload_req) ? LOAD_KICK : SWAP;
            reload_pend <= 1'b0;
          end else if (evo_wd == WD_LAST) begin
            state <= ERROR;
            error <= 1'b1;
          end else if (reload_req) begin
            reload_pend <= 1'b1;
          end
        end
        SWAP: begin
          buf_sel   <= ~buf_sel;
          gen_count <= gen_count + 1'b1;
          if (reload_req) reload_pend <= 1'b1;
          state     <= READY;
        end
        ERROR: begin
          if (reload_req) begin
            error <= 1'b0;
            state <= LOAD_KICK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = state inside {LOAD_KICK, LOAD_WAIT, EVO_KICK, EVO_WAIT};
  assign state_o = state;

endmodule
